// File: rtl/stage_sequencer.sv
// stage_sequencer: next-stage logic, request handshakes, bus timeout and sticky fault for the multi-cycle core
//   clk        : clock; all state updates on the rising edge
//   clear_n    : asynchronous active-low reset
//   stage_in   : current one-hot stage (bit 0 FETCH .. bit 4 WRITEBACK)
//   stage_next : next one-hot stage, combinational
//   halt       : hold in FETCH before a fetch request is issued
//   fetch_req  : registered fetch request; fetch_ack acknowledges it
//   mem_op     : instruction uses MEMORY, sampled in DECODE
//   wb_en      : instruction uses WRITEBACK, sampled in DECODE
//   exec_busy  : execute unit still busy
//   mem_req    : registered data request; mem_ack acknowledges it
//   fault      : sticky bus timeout or illegal stage vector
module stage_sequencer #(
  parameter int NUM_STAGES     = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic [NUM_STAGES-1:0] stage_in,
  output logic [NUM_STAGES-1:0] stage_next,
  input  logic                  halt,
  output logic                  fetch_req,
  input  logic                  fetch_ack,
  input  logic                  mem_op,
  input  logic                  wb_en,
  input  logic                  exec_busy,
  output logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  fault
);
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NUM_STAGES-1:0] FETCH     = NUM_STAGES'(1);
  localparam logic [NUM_STAGES-1:0] DECODE    = NUM_STAGES'(2);
  localparam logic [NUM_STAGES-1:0] EXECUTE   = NUM_STAGES'(4);
  localparam logic [NUM_STAGES-1:0] MEMORY    = NUM_STAGES'(8);
  localparam logic [NUM_STAGES-1:0] WRITEBACK = NUM_STAGES'(16);
  logic                 legal;
  logic                 fetch_hs;
  logic                 mem_hs;
  logic                 waiting;
  logic                 tmo;
  logic                 kill;
  logic                 mem_op_q;
  logic                 wb_en_q;
  logic [CNT_WIDTH-1:0] cnt;
  always_comb begin
    legal    = $onehot(stage_in);
    fetch_hs = fetch_req & fetch_ack;
    mem_hs   = mem_req & mem_ack;
    waiting  = (fetch_req & ~fetch_ack) | (mem_req & ~mem_ack);
    // the limit is reached on the edge that would make the count equal TIMEOUT_CYCLES
    tmo      = waiting && (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    kill     = fault | tmo | ~legal;
    stage_next = (!legal || fault) ? FETCH :
                 stage_in[0] ? (fetch_hs ? DECODE : FETCH) :
                 stage_in[1] ? EXECUTE :
                 stage_in[2] ? (exec_busy ? EXECUTE : mem_op_q ? MEMORY : wb_en_q ? WRITEBACK : FETCH) :
                 stage_in[3] ? (mem_hs ? (wb_en_q ? WRITEBACK : FETCH) : MEMORY) :
                 FETCH;
  end
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      fetch_req <= 1'b0;
      mem_req   <= 1'b0;
      fault     <= 1'b0;
      cnt       <= '0;
      mem_op_q  <= 1'b0;
      wb_en_q   <= 1'b0;
    end else begin
      fault     <= kill;
      cnt       <= (waiting && !tmo) ? cnt + CNT_WIDTH'(1) : '0;
      // an ack without its request is ignored because the request branch is not taken
      fetch_req <= !kill && (fetch_req ? !fetch_ack : (stage_in[0] && !halt));
      mem_req   <= !kill && (mem_req ? !mem_ack : stage_in[3]);
      if (legal && stage_in[1]) begin
        mem_op_q <= mem_op;
        wb_en_q  <= wb_en;
      end
    end
  end
endmodule
